// File: rtl/spike_lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted spike integration into a saturating
// potential, periodic linear leak, single-cycle output spike and refractory window.
module spike_lif_neuron #(
    parameter int W_POT       = 8,
    parameter int WEIGHT      = 16,
    parameter int THRESHOLD   = 64,
    parameter int LEAK_PERIOD = 16,
    parameter int LEAK_STEP   = 1,
    parameter int REFRACT     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_spike,
    input  logic             i_enable,
    output logic             o_spike,
    output logic [W_POT-1:0] o_potential,
    output logic             o_refractory,
    output logic [15:0]      o_spike_count
);

    localparam int TW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;
    localparam int SW = W_POT + 2;

    localparam logic [TW-1:0]        TIMER_LAST = TW'(LEAK_PERIOD - 1);
    localparam logic [RW-1:0]        REFR_LOAD  = RW'(REFRACT - 1);
    localparam logic [W_POT-1:0]     THR_V      = W_POT'(THRESHOLD);
    localparam logic signed [SW-1:0] POT_MAX    = SW'((1 << W_POT) - 1);
    localparam logic signed [SW-1:0] ADD_W      = SW'(WEIGHT);
    localparam logic signed [SW-1:0] SUB_L      = SW'(LEAK_STEP);

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [W_POT-1:0]   pot_q, pot_d;
    logic               spike_q, spike_d;
    logic               refr_q, refr_d;
    logic [15:0]        count_q, count_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;

    logic                 leak_tick_s;
    logic signed [SW-1:0] sum_s;
    logic [W_POT-1:0]     next_pot_s;

    // Leak timer and the clamped candidate potential for this cycle.
    always_comb begin
        leak_tick_s = (timer_q == TIMER_LAST);
        if (leak_tick_s) begin
            timer_d = {TW{1'b0}};
        end else begin
            timer_d = timer_q + TW'(1);
        end
        sum_s = $signed({2'b00, pot_q})
              + (i_spike ? ADD_W : SW'(0))
              - (leak_tick_s ? SUB_L : SW'(0));
        if (sum_s[SW-1]) begin
            next_pot_s = {W_POT{1'b0}};
        end else if (sum_s > POT_MAX) begin
            next_pot_s = POT_MAX[W_POT-1:0];
        end else begin
            next_pot_s = sum_s[W_POT-1:0];
        end
    end

    // State transition and next values of all registered outputs.
    always_comb begin
        state_d = state_q;
        pot_d   = pot_q;
        spike_d = 1'b0;
        refr_d  = refr_q;
        count_d = count_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_INTEGRATE: begin
                if (i_enable) begin
                    // Leak alone never fires: a spike must be present this cycle.
                    if (i_spike && (next_pot_s >= THR_V)) begin
                        spike_d = 1'b1;
                        pot_d   = {W_POT{1'b0}};
                        count_d = count_q + 16'd1;
                        refr_d  = 1'b1;
                        rcnt_d  = REFR_LOAD;
                        state_d = ST_REFRACTORY;
                    end else begin
                        pot_d = next_pot_s;
                    end
                end else begin
                    pot_d = pot_q;
                end
            end
            ST_REFRACTORY: begin
                pot_d = {W_POT{1'b0}};
                if (rcnt_q == {RW{1'b0}}) begin
                    refr_d  = 1'b0;
                    state_d = ST_INTEGRATE;
                end else begin
                    rcnt_d = rcnt_q - RW'(1);
                end
            end
            default: begin
                state_d = ST_INTEGRATE;
                pot_d   = {W_POT{1'b0}};
                refr_d  = 1'b0;
                rcnt_d  = {RW{1'b0}};
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_INTEGRATE;
            pot_q   <= {W_POT{1'b0}};
            spike_q <= 1'b0;
            refr_q  <= 1'b0;
            count_q <= 16'd0;
            timer_q <= {TW{1'b0}};
            rcnt_q  <= {RW{1'b0}};
        end else begin
            state_q <= state_d;
            pot_q   <= pot_d;
            spike_q <= spike_d;
            refr_q  <= refr_d;
            count_q <= count_d;
            timer_q <= timer_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign o_spike       = spike_q;
    assign o_potential   = pot_q;
    assign o_refractory  = refr_q;
    assign o_spike_count = count_q;

endmodule

// File: tb/tb_spike_lif_neuron.sv
// Scoreboard bench for spike_lif_neuron: three instances (defaults, WEIGHT=200
// and WEIGHT=100 with THRESHOLD=255) driven by directed vectors.
module tb_spike_lif_neuron;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    logic sp [3];
    logic        o_spk [3];
    logic [7:0]  o_pot [3];
    logic        o_refr [3];
    logic [15:0] o_cnt [3];

    typedef struct {
        int    sel;
        int    pot;
        int    spk;
        int    refr;
        int    cnt;
        string name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cur    = 0;
    int nxt    = 0;

    always #5 clk = ~clk;

    spike_lif_neuron u0 (
        .i_clk(clk), .i_rst(rst), .i_spike(sp[0]), .i_enable(en),
        .o_spike(o_spk[0]), .o_potential(o_pot[0]),
        .o_refractory(o_refr[0]), .o_spike_count(o_cnt[0])
    );

    spike_lif_neuron #(.WEIGHT(200), .THRESHOLD(255)) u1 (
        .i_clk(clk), .i_rst(rst), .i_spike(sp[1]), .i_enable(en),
        .o_spike(o_spk[1]), .o_potential(o_pot[1]),
        .o_refractory(o_refr[1]), .o_spike_count(o_cnt[1])
    );

    spike_lif_neuron #(.WEIGHT(100), .THRESHOLD(255)) u2 (
        .i_clk(clk), .i_rst(rst), .i_spike(sp[2]), .i_enable(en),
        .o_spike(o_spk[2]), .o_potential(o_pot[2]),
        .o_refractory(o_refr[2]), .o_spike_count(o_cnt[2])
    );

    task automatic push(input int sel, input int pot, input int spk,
                        input int refr, input int cnt, input string name);
        exp_t e;
        e.sel = sel; e.pot = pot; e.spk = spk; e.refr = refr; e.cnt = cnt; e.name = name;
        q.push_back(e);
    endtask

    task automatic drive(input logic s0, input logic s1, input logic s2,
                         input logic e, input logic r);
        @(negedge clk);
        rst = r; en = e; sp[0] = s0; sp[1] = s1; sp[2] = s2;
        cur = nxt;
        nxt = nxt + 1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int s = 0; s < 3; s++) push(s, 0, 0, 0, 0, "reset");
        nxt = 0;
    endtask

    // Monitor: outputs are compared one time unit after each rising edge.
    initial begin
        exp_t e;
        logic [25:0] act;
        logic [25:0] req;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                act = {o_spk[e.sel], o_refr[e.sel], o_pot[e.sel], o_cnt[e.sel]};
                req = {e.spk[0], e.refr[0], e.pot[7:0], e.cnt[15:0]};
                checks++;
                if (act !== req) begin
                    errors++;
                    $display("FAIL %s dut%0d got spk=%b refr=%b pot=%0d cnt=%0d want spk=%b refr=%b pot=%0d cnt=%0d",
                             e.name, e.sel, act[25], act[24], act[23:16], act[15:0],
                             req[25], req[24], req[23:16], req[15:0]);
                end
            end
        end
    end

    initial begin
        sp[0] = 1'b0; sp[1] = 1'b0; sp[2] = 1'b0;
        repeat (2) @(posedge clk);

        // Four spikes fire; spikes kept up through refractory are dropped.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            if (c <= 2)       push(0, 16 * (c + 1), 0, 0, 0, "integrate");
            else if (c == 3)  push(0, 0, 1, 1, 1, "fire");
            else if (c <= 10) push(0, 0, 0, 1, 1, "refract_hold");
            else if (c == 11) push(0, 0, 0, 0, 1, "refract_end");
            else              push(0, 16, 0, 0, 1, "post_refract_spike");
        end
        // Idle: leak ticks at timer==15.
        for (int c = 13; c <= 47; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (c == 14) push(0, 16, 0, 0, 1, "pre_leak");
            if (c == 15) push(0, 15, 0, 0, 1, "leak1");
            if (c == 31) push(0, 14, 0, 0, 1, "leak2");
            if (c == 47) push(0, 13, 0, 0, 1, "leak3");
        end
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(0, 0, 0, 0, 1, "leak_floor");

        // Saturating add reaches THRESHOLD=255.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        push(1, 200, 0, 0, 0, "w200_first");
        push(2, 100, 0, 0, 0, "w100_first");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        push(1, 0, 1, 1, 1, "w200_clamp_fire");
        push(2, 200, 0, 0, 0, "w100_second");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        push(2, 0, 1, 1, 1, "w100_clamp_fire");

        // Disabled: potential frozen, spikes and leak ticks lost.
        do_reset();
        for (int c = 0; c <= 2; c++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        push(0, 48, 0, 0, 0, "pre_disable");
        for (int c = 3; c <= 42; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (c == 3 || c == 42) push(0, 48, 0, 0, 0, "frozen");
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        push(0, 0, 1, 1, 1, "reenable_fire");

        // Reset in the third refractory cycle.
        do_reset();
        for (int c = 0; c <= 3; c++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        push(0, 0, 1, 1, 1, "fire_before_reset");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        push(0, 0, 0, 0, 0, "mid_refract_reset");
        nxt = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        push(0, 16, 0, 0, 0, "post_reset_spike");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_lif_neuron.md
# spike_lif_neuron

Leaky integrate-and-fire neuron that consumes the single-cycle spikes produced by the event-to-spike pulse generator. Each input spike adds a fixed weight to a saturating membrane potential. The potential leaks linearly at a fixed interval. Crossing the threshold emits a one-cycle output spike, followed by a refractory window during which input spikes are ignored.

## Interface
- `W_POT`, 8: membrane potential width in bits.
- `WEIGHT`, 16: potential increment per accepted input spike (1..2^W_POT-1).
- `THRESHOLD`, 64: firing threshold (1..2^W_POT-1); fire when potential ≥ THRESHOLD.
- `LEAK_PERIOD`, 16: cycles between leak ticks (≥2).
- `LEAK_STEP`, 1: potential decrement per leak tick.
- `REFRACT`, 8: refractory length in cycles (≥1).

Ports (clock and reset first):
- `i_clk`, in, 1: sole clock; all logic on rising edge.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_spike`, in, 1: single-cycle spike from the pulse generator.
- `i_enable`, in, 1: 1 = integrate and leak; 0 = potential frozen.
- `o_spike`, out, 1: single-cycle output spike.
- `o_potential`, out, W_POT: current membrane potential (registered).
- `o_refractory`, out, 1: high during the refractory window.
- `o_spike_count`, out, 16: number of output spikes since reset; wraps at 65535→0.

## Operation
- Reset (`i_rst`=1 at an edge): `o_spike`=0, `o_potential`=0, `o_refractory`=0, `o_spike_count`=0, state=INTEGRATE, leak timer=0, refractory counter=0.
- Leak timer is free-running 0..LEAK_PERIOD-1 in every state, regardless of `i_enable`. A leak tick occurs in the cycle where timer==LEAK_PERIOD-1.

INTEGRATE with `i_enable`=1, per cycle:
- Add = WEIGHT if `i_spike` else 0.
- Sub = LEAK_STEP if leak tick else 0.
- next = clamp(potential + add − sub, 0, 2^W_POT−1). Compute in W_POT+2 bits signed. The add and the leak in the same cycle both apply.
- If `i_spike`=1 and next ≥ THRESHOLD:
  - `o_spike`←1, potential←0, `o_spike_count`←+1.
  - `o_refractory`←1, refractory counter←REFRACT−1, state←REFRACTORY.
- Else potential←next.
- A leak alone never causes firing; firing requires a spike in the same cycle.

INTEGRATE with `i_enable`=0:
- Potential holds and `i_spike` is dropped.
- Leak timer still advances; ticks in this state are lost.

REFRACTORY:
- `i_spike` is dropped, potential held at 0, `o_spike`=0 after its first cycle.
- Counter decrements each cycle. When the counter==0 at an edge: `o_refractory`←0, state←INTEGRATE.
- `i_enable` has no effect on the countdown.
- A spike in the first cycle after `o_refractory` falls is accepted.

Mid-operation reset: same-edge return to reset values from any state. There is no pending output spike after reset.

## Timing
- Latency: `i_spike` high in cycle n with a crossing → `o_spike` high exactly in cycle n+1, for one cycle.
- `o_refractory` is high in cycles n+1..n+REFRACT inclusive (REFRACT cycles, including the `o_spike` cycle).
- `o_potential` reflects the update one cycle after the sampled input. It reads 0 in cycle n+1 when firing.
- Maximum firing rate: one spike every REFRACT+1 cycles.
- Back-to-back input spikes (every cycle) are all accepted in INTEGRATE.

## Test plan
- Defaults, reset then four `i_spike` pulses in consecutive cycles:
  - `o_potential` 16, 32, 48.
  - `o_spike` high the cycle after the 4th pulse; `o_potential`=0, `o_spike_count`=1.
  - `o_refractory` high 8 cycles.
- Defaults, one spike, then idle 40 cycles:
  - Potential 16 decrements by 1 at each leak tick (timer==15): 15 after the first tick, 14 after the second.
  - Floors at 0 in a long idle run (≥256 cycles), never wraps.
- Defaults, fire, then one spike every cycle through refractory:
  - All refractory spikes dropped; potential 0 for 8 cycles.
  - The spike in cycle n+9 gives potential 16.
- W_POT=8, WEIGHT=200, THRESHOLD=255:
  - Two spikes → sum clamps to 255 ≥ threshold → fires on the second spike, count=1.
  - With THRESHOLD=255 and WEIGHT=100, three spikes → 100, 200, 255 clamp → fire.
- `i_enable`=0 with potential 48, spikes plus 40 cycles:
  - Potential stays 48, no leak.
  - Re-enable and one spike → fire.
- Reset asserted mid-refractory (3rd refractory cycle):
  - Next cycle all outputs 0, `o_spike_count`=0.
  - An immediate spike is accepted (potential 16).
